tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Receive side of the 4-channel time-division path: the inverse of the 4:1 selector that interleaves four channels onto one line.
- Takes a 1-bit serial stream carrying four channels in fixed slot order (ch0, ch1, ch2, ch3).
- Locks to a frame-sync marker and deserializes each channel into a WORD_W-bit word, MSB first.
- Presents all four words in parallel with a one-cycle valid strobe.

Parameters:
WORD_W, 8, bits per channel word (frames per word); legal range 2..32
MISS_LIMIT, 2, consecutive missing frame syncs at slot 0 before lock is dropped; legal range 1..7

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
din  input  1  serial TDM data bit
din_valid  input  1  din and fsync sampled only when 1
fsync  input  1  frame marker; high with the slot-0 (ch0) bit of each frame
y0  output  WORD_W  last completed ch0 word
y1  output  WORD_W  last completed ch1 word
y2  output  WORD_W  last completed ch2 word
y3  output  WORD_W  last completed ch3 word
word_valid  output  1  one-cycle pulse: y0..y3 just updated
locked  output  1  1 while frame alignment is held
sync_err  output  1  one-cycle pulse on misplaced fsync
slot  output  2  slot index expected for the next accepted bit (0 in HUNT)

Behaviour:
- Reset (rst=1 at clk edge): y0..y3=0, word_valid=0, locked=0, sync_err=0, slot=0; state HUNT.
  - Clears the slot counter, frame counter, miss counter and all four shift registers.
  - rst overrides every other input in the same cycle.
  - A reset mid-word discards the partial word and raises no word_valid.
- din_valid=0: no state changes; word_valid and sync_err are 0 the following cycle.
- HUNT state:
  - Bits are ignored until din_valid=1 and fsync=1.
  - That bit is taken as ch0 of frame 0: it is shifted into sr0, then state=LOCK, slot=1, frame=0, miss=0.
  - locked=1 from the next cycle.
- LOCK state, on each accepted bit (din_valid=1):
  - sr[slot] <= {sr[slot][WORD_W-2:0], din}.
  - slot <= slot+1, wrapping 3->0.
  - frame increments when a slot-3 bit is accepted; wraps WORD_W-1 -> 0.
- Word completion:
  - Trigger: the edge that accepts the slot-3 bit of frame WORD_W-1.
  - y0..y2 load their completed shift registers; y3 loads {sr3[WORD_W-2:0], din}.
  - word_valid=1 for exactly that next cycle.
  - Latency: outputs visible one cycle after the last bit is sampled.
  - y0..y3 hold their values until the next completion or reset.
- Sync checking in LOCK:
  - fsync=1 at slot 0: good frame; miss <= 0.
  - fsync=0 at slot 0: miss <= miss+1.
    - If miss reaches MISS_LIMIT: go to HUNT, locked=0 next cycle, partial words discarded.
    - The bit that caused the drop is not shifted.
    - Otherwise the bit is processed normally (flywheel).
  - fsync=1 at slot 1..3: sync_err=1 for one cycle; immediate realign.
    - The current bit becomes ch0 of frame 0: shift registers cleared, then the bit loaded into sr0.
    - slot=1, frame=0, miss=0; locked stays 1.
    - No word_valid for the discarded partial word.
  - Lock drop and word completion cannot coincide: completion happens at slot 3, misses are counted at slot 0.
- Arithmetic:
  - slot is a 2-bit wrap counter.
  - frame counter is ceil(log2(WORD_W)) bits and compares against WORD_W-1.
  - miss counter is 3 bits, saturating at MISS_LIMIT.

Test Plan:
- Reset: rst=1 for 2 cycles with din=1, fsync=1, din_valid=1 -> all outputs 0, locked=0, no word_valid.
- Lock and deliver:
  - Stimulus: WORD_W=8, continuous din_valid; 8 frames with fsync on every slot 0; ch0=0xA5, ch1=0x3C, ch2=0xFF, ch3=0x01, MSB first.
  - Response: locked=1 after the first bit; one word_valid the cycle after bit 32 with y0=0xA5, y1=0x3C, y2=0xFF, y3=0x01; slot=0 afterwards.
- Gapped input: same stream with din_valid low every other cycle -> identical y values; exactly one word_valid; no sync_err.
- Misplaced fsync:
  - Stimulus: fsync=1 at slot 2 of frame 3, then a full clean 8-frame word ch0..ch3=0x11,0x22,0x33,0x44.
  - Response: sync_err pulses once; locked stays 1; no word_valid for the partial word; next word_valid carries 0x11, 0x22, 0x33, 0x44.
- Lost sync (MISS_LIMIT=2):
  - Stimulus: two consecutive slot-0 bits with fsync=0.
  - Response: locked=0 the cycle after the second miss; no word_valid; re-lock on the next fsync followed by a correct 32-bit word.
- Reset mid-word: rst=1 after 20 accepted bits -> y0..y3 return to 0, locked=0, and word_valid stays 0 through bit 32.

Source files
------------

// File: rtl/tdm_demux4.sv
// Receive-side 4-channel TDM deserializer: locks to the slot-0 frame marker and
// rebuilds one WORD_W-bit word per channel, MSB first, presented in parallel.
module tdm_demux4 #(
    parameter int WORD_W     = 8,
    parameter int MISS_LIMIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_valid,
    input  logic              fsync,
    output logic [WORD_W-1:0] y0,
    output logic [WORD_W-1:0] y1,
    output logic [WORD_W-1:0] y2,
    output logic [WORD_W-1:0] y3,
    output logic              word_valid,
    output logic              locked,
    output logic              sync_err,
    output logic [1:0]        slot
);

    localparam int FRAME_W = $clog2(WORD_W);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(WORD_W - 1);
    localparam logic [2:0]         MISS_MAX   = 3'(MISS_LIMIT);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t               state_q, state_n;
    logic [1:0]           slot_q, slot_n;
    logic [FRAME_W-1:0]   frame_q, frame_n;
    logic [2:0]           miss_q, miss_n;
    logic [WORD_W-1:0]    sr_q [4];
    logic [WORD_W-1:0]    sr_n [4];
    logic [WORD_W-1:0]    y_q  [4];
    logic [WORD_W-1:0]    y_n  [4];
    logic                 wv_q, wv_n;
    logic                 se_q, se_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            slot_q  <= '0;
            frame_q <= '0;
            miss_q  <= '0;
            wv_q    <= 1'b0;
            se_q    <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                sr_q[i] <= '0;
                y_q[i]  <= '0;
            end
        end else begin
            state_q <= state_n;
            slot_q  <= slot_n;
            frame_q <= frame_n;
            miss_q  <= miss_n;
            wv_q    <= wv_n;
            se_q    <= se_n;
            for (int unsigned i = 0; i < 4; i++) begin
                sr_q[i] <= sr_n[i];
                y_q[i]  <= y_n[i];
            end
        end
    end

    always_comb begin
        state_n = state_q;
        slot_n  = slot_q;
        frame_n = frame_q;
        miss_n  = miss_q;
        wv_n    = 1'b0;
        se_n    = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            sr_n[i] = sr_q[i];
            y_n[i]  = y_q[i];
        end

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (fsync) begin
                        for (int unsigned i = 0; i < 4; i++) sr_n[i] = '0;
                        sr_n[0] = WORD_W'(din);
                        state_n = LOCK;
                        slot_n  = 2'd1;
                        frame_n = '0;
                        miss_n  = '0;
                    end
                end
                LOCK: begin
                    if (fsync && slot_q != 2'd0) begin
                        // Misplaced marker: this bit restarts the frame as ch0 of frame 0
                        se_n = 1'b1;
                        for (int unsigned i = 0; i < 4; i++) sr_n[i] = '0;
                        sr_n[0] = WORD_W'(din);
                        slot_n  = 2'd1;
                        frame_n = '0;
                        miss_n  = '0;
                    end else if (!fsync && slot_q == 2'd0 && (miss_q + 3'd1) >= MISS_MAX) begin
                        state_n = HUNT;
                        for (int unsigned i = 0; i < 4; i++) sr_n[i] = '0;
                        slot_n  = '0;
                        frame_n = '0;
                        miss_n  = '0;
                    end else begin
                        if (slot_q == 2'd0)
                            miss_n = fsync ? 3'd0 : miss_q + 3'd1;
                        sr_n[slot_q] = {sr_q[slot_q][WORD_W-2:0], din};
                        slot_n = slot_q + 2'd1;
                        if (slot_q == 2'd3) begin
                            frame_n = (frame_q == FRAME_LAST) ? '0 : frame_q + FRAME_W'(1);
                            if (frame_q == FRAME_LAST) begin
                                y_n[0] = sr_q[0];
                                y_n[1] = sr_q[1];
                                y_n[2] = sr_q[2];
                                y_n[3] = {sr_q[3][WORD_W-2:0], din};
                                wv_n   = 1'b1;
                            end
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    assign y0         = y_q[0];
    assign y1         = y_q[1];
    assign y2         = y_q[2];
    assign y3         = y_q[3];
    assign word_valid = wv_q;
    assign sync_err   = se_q;
    assign locked     = (state_q == LOCK);
    assign slot       = slot_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (WORD_W=8, MISS_LIMIT=2) with hand-computed words.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst, din, din_valid, fsync;
    logic [7:0] y0, y1, y2, y3;
    logic       word_valid, locked, sync_err;
    logic [1:0] slot;

    int n_cmp = 0;
    int n_bad = 0;
    int wv_cnt = 0;
    int se_cnt = 0;

    tdm_demux4 #(.WORD_W(8), .MISS_LIMIT(2)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .fsync(fsync),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .word_valid(word_valid), .locked(locked), .sync_err(sync_err), .slot(slot)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1ns after the rising edge.
    task automatic send_bit(input logic d, input logic fs, input logic v);
        @(negedge clk);
        din = d; fsync = fs; din_valid = v;
        @(posedge clk);
        #1;
        if (word_valid) wv_cnt++;
        if (sync_err) se_cnt++;
    endtask

    task automatic send_bits(input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input logic [7:0] w3,
                             input int first, input int n, input bit gap);
        logic [7:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int k = first; k < first + n; k++) begin
            if (gap) send_bit(1'b1, 1'b1, 1'b0);
            send_bit(w[k % 4][7 - k / 4], (k % 4) == 0, 1'b1);
        end
    endtask

    task automatic check_y(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
        check({tag, "_y0"}, 32'(y0), 32'(e0));
        check({tag, "_y1"}, 32'(y1), 32'(e1));
        check({tag, "_y2"}, 32'(y2), 32'(e2));
        check({tag, "_y3"}, 32'(y3), 32'(e3));
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1; din = 1'b1; fsync = 1'b1; din_valid = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        if (word_valid) wv_cnt++;
        if (sync_err) se_cnt++;
        @(negedge clk);
        rst = 1'b0; din_valid = 1'b0; fsync = 1'b0; din = 1'b0;
    endtask

    initial begin
        rst = 1'b0; din = 1'b0; din_valid = 1'b0; fsync = 1'b0;

        // Reset with all inputs high
        do_reset(2);
        check_y("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        check("rst_locked", 32'(locked), 0);
        check("rst_wv", 32'(word_valid), 0);
        check("rst_se", 32'(sync_err), 0);
        check("rst_slot", 32'(slot), 0);

        // Lock and deliver
        wv_cnt = 0; se_cnt = 0;
        send_bits(8'hA5, 8'h3C, 8'hFF, 8'h01, 0, 1, 1'b0);
        check("lock_first", 32'(locked), 1);
        check("lock_slot1", 32'(slot), 1);
        send_bits(8'hA5, 8'h3C, 8'hFF, 8'h01, 1, 30, 1'b0);
        check("lock_no_early_wv", 32'(wv_cnt), 0);
        send_bits(8'hA5, 8'h3C, 8'hFF, 8'h01, 31, 1, 1'b0);
        check("lock_wv_pulse", 32'(word_valid), 1);
        check_y("lock", 8'hA5, 8'h3C, 8'hFF, 8'h01);
        check("lock_slot0", 32'(slot), 0);
        send_bit(1'b0, 1'b0, 1'b0);
        check("lock_wv_one_cycle", 32'(word_valid), 0);
        check("lock_wv_count", 32'(wv_cnt), 1);

        // Gapped input, starting from reset so the values must be rebuilt
        do_reset(1);
        wv_cnt = 0; se_cnt = 0;
        send_bits(8'hA5, 8'h3C, 8'hFF, 8'h01, 0, 32, 1'b1);
        check_y("gap", 8'hA5, 8'h3C, 8'hFF, 8'h01);
        check("gap_wv_count", 32'(wv_cnt), 1);
        check("gap_se_count", 32'(se_cnt), 0);
        send_bit(1'b1, 1'b1, 1'b0);
        check("gap_hold_wv", 32'(word_valid), 0);
        check("gap_hold_slot", 32'(slot), 0);

        // Misplaced fsync at slot 2 of frame 3; that bit starts the clean word
        wv_cnt = 0; se_cnt = 0;
        send_bits(8'hDE, 8'hAD, 8'hBE, 8'hEF, 0, 14, 1'b0);
        check("mis_slot2", 32'(slot), 2);
        send_bit(1'b0, 1'b1, 1'b1);
        check("mis_se_pulse", 32'(sync_err), 1);
        check("mis_locked", 32'(locked), 1);
        check("mis_slot_realign", 32'(slot), 1);
        send_bits(8'h11, 8'h22, 8'h33, 8'h44, 1, 30, 1'b0);
        check("mis_no_partial_wv", 32'(wv_cnt), 0);
        send_bits(8'h11, 8'h22, 8'h33, 8'h44, 31, 1, 1'b0);
        check("mis_wv_pulse", 32'(word_valid), 1);
        check_y("mis", 8'h11, 8'h22, 8'h33, 8'h44);
        check("mis_se_count", 32'(se_cnt), 1);

        // Lost sync: two consecutive slot-0 misses
        wv_cnt = 0; se_cnt = 0;
        send_bit(1'b1, 1'b0, 1'b1);
        check("loss_flywheel", 32'(locked), 1);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        check("loss_still_locked", 32'(locked), 1);
        send_bit(1'b1, 1'b0, 1'b1);
        check("loss_unlocked", 32'(locked), 0);
        check("loss_slot", 32'(slot), 0);
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        check("loss_hunt_ignores", 32'(locked), 0);
        check("loss_no_wv", 32'(wv_cnt), 0);
        check_y("loss_hold", 8'h11, 8'h22, 8'h33, 8'h44);
        send_bits(8'h5A, 8'hC3, 8'h96, 8'h69, 0, 32, 1'b0);
        check("relock_wv_count", 32'(wv_cnt), 1);
        check_y("relock", 8'h5A, 8'hC3, 8'h96, 8'h69);

        // Reset mid-word after 20 accepted bits
        wv_cnt = 0;
        send_bits(8'h0F, 8'hF0, 8'hAA, 8'h55, 0, 20, 1'b0);
        do_reset(1);
        check_y("midrst", 8'h00, 8'h00, 8'h00, 8'h00);
        check("midrst_locked", 32'(locked), 0);
        send_bits(8'h0F, 8'hF0, 8'hAA, 8'h55, 20, 12, 1'b0);
        check("midrst_no_wv", 32'(wv_cnt), 0);
        check_y("midrst_hold", 8'h00, 8'h00, 8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
